// File: rtl/crc8_frame_ctrl_if.sv
// crc8_frame_ctrl_if: byte stream from the framing source into the CRC frame controller
interface crc8_frame_ctrl_if;
    logic       mode;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       abort;
    modport master(output mode, in_data, in_valid, in_last, abort, input in_ready);
    modport slave(input mode, in_data, in_valid, in_last, abort, output in_ready);
endinterface

// File: rtl/crc8_frame_ctrl.sv
// crc8_frame_ctrl: byte-framed sequencer around a bit-serial CRC-8 (poly 0x31, MSB-first,
// no reflection); reports the frame CRC in gen mode or a zero-residue check in check mode.
module crc8_frame_ctrl #(
    parameter logic [7:0] INIT      = 8'h00,
    parameter int         MAX_BYTES = 255,
    parameter int         CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    crc8_frame_ctrl_if.slave     s,
    output logic                 busy,
    output logic                 crc_valid,
    output logic [7:0]           crc_out,
    output logic                 crc_ok,
    output logic                 len_err,
    output logic [CNT_W-1:0]     byte_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
    state_t     state, state_n;
    logic [7:0] crc, crc_n, data_q, crc_hold;
    logic [2:0] idx;
    logic       last_q, mode_q, len_flag, xfer, b, done_v;
    assign s.in_ready = state == IDLE && !s.abort && !rst;
    assign xfer       = s.in_ready && s.in_valid;
    assign b          = data_q[idx] ^ crc[7];
    assign crc_n      = {crc[6:0], 1'b0} ^ (b ? 8'h31 : 8'h00);
    // an abort landing on the DONE cycle suppresses the result entirely
    assign done_v     = state == DONE && !s.abort && !rst;
    assign busy       = state != IDLE || byte_cnt != '0;
    assign crc_valid  = done_v;
    assign crc_out    = done_v ? crc : crc_hold;
    assign crc_ok     = done_v && mode_q && crc == 8'h00 && !len_flag;
    assign len_err    = done_v && len_flag;
    always_comb begin
        state_n = state;
        state_n = s.abort          ? IDLE :
                  state == IDLE    ? (xfer ? SHIFT : IDLE) :
                  state == SHIFT   ? (idx != 3'd0 ? SHIFT : last_q ? DONE : IDLE) :
                                     IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            crc      <= INIT;
            crc_hold <= 8'h00;
            data_q   <= 8'h00;
            idx      <= 3'd0;
            last_q   <= 1'b0;
            mode_q   <= 1'b0;
            len_flag <= 1'b0;
            byte_cnt <= '0;
        end else begin
            state <= state_n;
            if (s.abort) begin
                crc      <= INIT;
                byte_cnt <= '0;
                len_flag <= 1'b0;
            end else if (xfer) begin
                data_q <= s.in_data;
                last_q <= s.in_last;
                idx    <= 3'd7;
                if (byte_cnt == '0) mode_q <= s.mode;
                if (byte_cnt == MAX_CNT) len_flag <= 1'b1;
                else byte_cnt <= byte_cnt + CNT_W'(1);
            end else if (state == SHIFT) begin
                crc <= crc_n;
                idx <= idx - 3'd1;
            end else if (state == DONE) begin
                crc_hold <= crc;
                crc      <= INIT;
                byte_cnt <= '0;
                len_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// tb_crc8_frame_ctrl: directed and randomized frames against a byte-wise CRC-8 model;
// a second instance with MAX_BYTES=2 sees the same stimulus to exercise length overflow.
module tb_crc8_frame_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0, in_valid = 1'b0, in_last = 1'b0, abort = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       busy_a, cv_a, ok_a, le_a, busy_b, cv_b, ok_b, le_b;
    logic [7:0] co_a, co_b, bc_a, bc_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    crc8_frame_ctrl_if ia();
    crc8_frame_ctrl_if ib();
    assign ia.mode = mode;  assign ia.in_data = in_data;  assign ia.in_valid = in_valid;
    assign ia.in_last = in_last;  assign ia.abort = abort;
    assign ib.mode = mode;  assign ib.in_data = in_data;  assign ib.in_valid = in_valid;
    assign ib.in_last = in_last;  assign ib.abort = abort;

    crc8_frame_ctrl dut_a (.clk(clk), .rst(rst), .s(ia.slave), .busy(busy_a), .crc_valid(cv_a),
                           .crc_out(co_a), .crc_ok(ok_a), .len_err(le_a), .byte_cnt(bc_a));
    crc8_frame_ctrl #(.MAX_BYTES(2)) dut_b (.clk(clk), .rst(rst), .s(ib.slave), .busy(busy_b),
                           .crc_valid(cv_b), .crc_out(co_b), .crc_ok(ok_b), .len_err(le_b),
                           .byte_cnt(bc_b));

    // byte-at-a-time CRC-8/0x31 reference
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h31) : (r << 1);
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic l, input logic m);
        int n;
        in_data = d; in_last = l; mode = m; in_valid = 1'b1;
        #1;
        n = 0;
        while (!ia.in_ready && n < 30) begin @(negedge clk); #1; n++; end
        checks++;
        if (n >= 30) begin errors++; $display("FAIL accept_timeout got in_ready %b exp 1", ia.in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!cv_a && lat < 30) begin @(negedge clk); lat++; end
    endtask

    task automatic test_reset;
        in_valid = 1'b1; in_data = 8'hA5;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({ia.in_ready, busy_a, cv_a, ok_a, le_a} !== 5'b0)
            begin errors++; $display("FAIL reset_flags got %b exp 00000", {ia.in_ready, busy_a, cv_a, ok_a, le_a}); end
        checks++;
        if (co_a !== 8'h00 || bc_a !== 8'h00)
            begin errors++; $display("FAIL reset_vals got crc %h cnt %0d exp 00 0", co_a, bc_a); end
        in_valid = 1'b0; rst = 1'b0;
        #1;
        checks++;
        if (ia.in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset got %b exp 1", ia.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single;
        int lat;
        send_byte(8'h01, 1'b1, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL single_latency got %0d exp 9", lat); end
        checks++;
        if (co_a !== 8'h31) begin errors++; $display("FAIL single01_crc got %h exp 31", co_a); end
        checks++;
        if ({ok_a, le_a} !== 2'b00) begin errors++; $display("FAIL single01_flags got %b exp 00", {ok_a, le_a}); end
        checks++;
        if (bc_a !== 8'd1) begin errors++; $display("FAIL single01_cnt got %0d exp 1", bc_a); end
        @(negedge clk);
        checks++;
        if (cv_a !== 1'b0 || co_a !== 8'h31)
            begin errors++; $display("FAIL single_hold got valid %b crc %h exp 0 31", cv_a, co_a); end
        send_byte(8'h80, 1'b1, 1'b0);
        wait_done(lat);
        checks++;
        if (co_a !== 8'h7A) begin errors++; $display("FAIL single80_crc got %h exp 7a", co_a); end
        @(negedge clk);
        send_byte(8'h01, 1'b1, 1'b0);
        wait_done(lat);
        checks++;
        if (co_a !== 8'h31) begin errors++; $display("FAIL reinit_crc got %h exp 31", co_a); end
        @(negedge clk);
    endtask

    task automatic test_check;
        int lat;
        send_byte(8'h01, 1'b0, 1'b1);
        send_byte(8'h31, 1'b1, 1'b0);
        wait_done(lat);
        checks++;
        if (co_a !== 8'h00 || ok_a !== 1'b1)
            begin errors++; $display("FAIL check_good got crc %h ok %b exp 00 1", co_a, ok_a); end
        @(negedge clk);
        send_byte(8'h01, 1'b0, 1'b1);
        send_byte(8'h30, 1'b1, 1'b1);
        wait_done(lat);
        checks++;
        if (co_a !== 8'h31 || ok_a !== 1'b0)
            begin errors++; $display("FAIL check_bad got crc %h ok %b exp 31 0", co_a, ok_a); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int acc[3];
        int k, lat;
        logic [7:0] bs[3];
        bs[0] = 8'($urandom); bs[1] = 8'($urandom);
        bs[2] = crc_step(crc_step(8'h00, bs[0]), bs[1]);
        k = 0;
        in_data = bs[0]; in_last = 1'b0; mode = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 60 && k < 3; c++) begin
            #1;
            if (ia.in_ready) begin acc[k] = c; k++; end
            @(posedge clk); @(negedge clk);
            if (k > 0 && acc[k-1] == c) begin
                if (k < 3) begin in_data = bs[k]; in_last = (k == 2); mode = 1'b0; end
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (k !== 3) begin errors++; $display("FAIL b2b_accepts got %0d exp 3", k); end
        else begin
            checks++;
            if (acc[1] - acc[0] !== 9 || acc[2] - acc[1] !== 9)
                begin errors++; $display("FAIL b2b_spacing got %0d %0d exp 9 9", acc[1] - acc[0], acc[2] - acc[1]); end
        end
        wait_done(lat);
        checks++;
        if (lat !== 9 || co_a !== 8'h00 || ok_a !== 1'b1)
            begin errors++; $display("FAIL b2b_result got lat %0d crc %h ok %b exp 9 00 1", lat, co_a, ok_a); end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int lat, seen;
        send_byte(8'h80, 1'b1, 1'b0);
        wait_done(lat);
        @(negedge clk);
        send_byte(8'h55, 1'b0, 1'b1);
        send_byte(8'hAA, 1'b0, 1'b1);
        @(negedge clk); @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h11;
        @(negedge clk); @(negedge clk);
        checks++;
        if (bc_a !== 8'd0 || busy_a !== 1'b0)
            begin errors++; $display("FAIL abort_clear got cnt %0d busy %b exp 0 0", bc_a, busy_a); end
        in_valid = 1'b0; abort = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin @(negedge clk); if (cv_a) seen++; end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_no_valid got %0d exp 0", seen); end
        checks++;
        if (co_a !== crc_step(8'h00, 8'h80)) begin errors++; $display("FAIL abort_hold got %h exp 7a", co_a); end
        send_byte(8'h01, 1'b0, 1'b1);
        send_byte(8'h31, 1'b1, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 9 || co_a !== 8'h00 || ok_a !== 1'b1)
            begin errors++; $display("FAIL abort_next got lat %0d crc %h ok %b exp 9 00 1", lat, co_a, ok_a); end
        @(negedge clk);
    endtask

    task automatic test_len_and_rst;
        int lat;
        send_byte(8'h01, 1'b0, 1'b1);
        send_byte(8'h31, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        wait_done(lat);
        checks++;
        if ({cv_b, le_b, ok_b} !== 3'b110 || bc_b !== 8'd2 || co_b !== 8'h00)
            begin errors++; $display("FAIL len_b got v%b le%b ok%b cnt %0d crc %h exp 110 2 00", cv_b, le_b, ok_b, bc_b, co_b); end
        checks++;
        if ({le_a, ok_a} !== 2'b01 || bc_a !== 8'd3)
            begin errors++; $display("FAIL len_a got le%b ok%b cnt %0d exp 01 3", le_a, ok_a, bc_a); end
        @(negedge clk);
        send_byte(8'h80, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ia.in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", ia.in_ready); end
        @(negedge clk);
        checks++;
        if ({busy_a, cv_a, ok_a, le_a, busy_b, cv_b, ok_b, le_b} !== 8'h00 || co_a !== 8'h00 || bc_a !== 8'h00 || co_b !== 8'h00 || bc_b !== 8'h00)
            begin errors++; $display("FAIL rst_mid got a %b %h %0d b %b %h %0d exp zeros", {busy_a, cv_a, ok_a, le_a}, co_a, bc_a, {busy_b, cv_b, ok_b, le_b}, co_b, bc_b); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random;
        int len, lat;
        logic m;
        logic [7:0] c, d;
        logic [7:0] fb[4];
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 4);
            m = 1'($urandom_range(0, 1));
            c = 8'h00;
            for (int i = 0; i < len; i++) begin
                d = 8'($urandom);
                if (m && len > 1 && i == len - 1 && $urandom_range(0, 1) == 1) d = c;
                fb[i] = d;
                c = crc_step(c, d);
            end
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send_byte(fb[i], i == len - 1, i == 0 ? m : 1'($urandom_range(0, 1)));
            end
            wait_done(lat);
            checks++;
            if (lat !== 9 || co_a !== c || ok_a !== (m && c == 8'h00) || le_a !== 1'b0 || bc_a !== 8'(len))
                begin errors++; $display("FAIL rand_a f%0d got lat %0d crc %h ok %b le %b cnt %0d exp 9 %h %b 0 %0d", f, lat, co_a, ok_a, le_a, bc_a, c, m && c == 8'h00, len); end
            checks++;
            if (ok_b !== (m && c == 8'h00 && len <= 2) || le_b !== (len > 2) || bc_b !== 8'(len > 2 ? 2 : len))
                begin errors++; $display("FAIL rand_b f%0d got ok %b le %b cnt %0d exp %b %b %0d", f, ok_b, le_b, bc_b, m && c == 8'h00 && len <= 2, len > 2, len > 2 ? 2 : len); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_check;
        test_back_to_back;
        test_abort;
        test_len_and_rst;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
